// File: rtl/one_hot_state_register_param.sv
// N-state one-hot state register with parallel load, rotate-advance, DFT scan
// shifting, continuous encoding check with optional recovery, and a sticky error flag.
module one_hot_state_register_param #(
    parameter int N         = 4,
    parameter int RESET_IDX = 0,
    parameter int RECOVER   = 1,
    localparam int IW       = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          advance,
    input  logic [N-1:0]  state_in,
    input  logic          scan_enable,
    input  logic          scan_in,
    input  logic          err_clr,
    output logic [N-1:0]  state_out,
    output logic [IW-1:0] state_idx,
    output logic          scan_out,
    output logic          illegal,
    output logic          err_sticky
);

    localparam logic [N-1:0] RESET_VAL = {{(N-1){1'b0}}, 1'b1} << RESET_IDX;

    logic [N-1:0] state_r;
    logic         err_r;
    logic [N-1:0] next_state_s;
    logic         next_err_s;
    logic         err_cond_s;
    logic         illegal_s;
    logic         load_ok_s;

    function automatic logic is_onehot(input logic [N-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return (cnt == 1);
    endfunction

    // Lowest set bit wins, so scanning from the top leaves the smallest index.
    function automatic logic [IW-1:0] low_idx(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    assign illegal_s = !is_onehot(state_r);
    assign load_ok_s = is_onehot(state_in);

    // Next-state and error-flag selection in priority order.
    always_comb begin
        next_state_s = state_r;
        next_err_s   = err_r;
        err_cond_s   = 1'b0;
        if (scan_enable) begin
            next_state_s = {state_r[N-2:0], scan_in};
        end else begin
            if (enable) begin
                if (load_ok_s) begin
                    next_state_s = state_in;
                end else begin
                    err_cond_s = 1'b1;
                end
            end else if (illegal_s && (RECOVER != 0)) begin
                next_state_s = RESET_VAL;
                err_cond_s   = 1'b1;
            end else if (advance) begin
                next_state_s = {state_r[N-2:0], state_r[N-1]};
                err_cond_s   = illegal_s;
            end else begin
                err_cond_s = illegal_s;
            end
            // Set beats clear when both happen in one cycle.
            if (err_cond_s) begin
                next_err_s = 1'b1;
            end else if (err_clr) begin
                next_err_s = 1'b0;
            end else begin
                next_err_s = err_r;
            end
        end
    end

    // State and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RESET_VAL;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            err_r   <= next_err_s;
        end
    end

    assign state_out  = state_r;
    assign err_sticky = err_r;
    assign illegal    = illegal_s;
    assign scan_out   = state_r[N-1];
    assign state_idx  = illegal_s ? '0 : low_idx(state_r);

endmodule

// File: tb/tb_one_hot_state_register_param.sv
// Randomised and directed bench for one_hot_state_register_param: three instances
// (N=4 recovering, N=4 flag-only, N=8 reset at bit 7) against a behavioural model.
module tb_one_hot_state_register_param;

    logic       clk = 1'b0;
    logic       rst, enable, advance, scan_enable, scan_in, err_clr;
    logic [7:0] sin;

    logic [3:0] a_state, b_state;
    logic [7:0] c_state;
    logic [1:0] a_idx, b_idx;
    logic [2:0] c_idx;
    logic       a_so, b_so, c_so, a_ill, b_ill, c_ill, a_err, b_err, c_err;

    int checks = 0;
    int errors = 0;
    logic armed = 1'b0;
    logic [8:0] ma, mb, mc;   // {err_sticky, state} of the model for each instance

    always #5 clk = ~clk;

    one_hot_state_register_param #(.N(4), .RESET_IDX(0), .RECOVER(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .advance(advance), .state_in(sin[3:0]),
        .scan_enable(scan_enable), .scan_in(scan_in), .err_clr(err_clr),
        .state_out(a_state), .state_idx(a_idx), .scan_out(a_so), .illegal(a_ill),
        .err_sticky(a_err));

    one_hot_state_register_param #(.N(4), .RESET_IDX(0), .RECOVER(0)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .advance(advance), .state_in(sin[3:0]),
        .scan_enable(scan_enable), .scan_in(scan_in), .err_clr(err_clr),
        .state_out(b_state), .state_idx(b_idx), .scan_out(b_so), .illegal(b_ill),
        .err_sticky(b_err));

    one_hot_state_register_param #(.N(8), .RESET_IDX(7), .RECOVER(1)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .advance(advance), .state_in(sin),
        .scan_enable(scan_enable), .scan_in(scan_in), .err_clr(err_clr),
        .state_out(c_state), .state_idx(c_idx), .scan_out(c_so), .illegal(c_ill),
        .err_sticky(c_err));

    // Behavioural next value from the priority rules, on an 8-bit masked vector.
    function automatic logic [8:0] model_next(input int n, input int ridx, input int rec,
                                              input logic [8:0] cur);
        logic [7:0] mask, s, d, ns;
        logic       bad, errc, ne;
        mask = 8'((1 << n) - 1);
        s    = cur[7:0] & mask;
        d    = sin & mask;
        bad  = ($countones(s) != 1);
        ns   = s;
        errc = 1'b0;
        if (rst) return {1'b0, 8'(1 << ridx)};
        if (scan_enable) return {cur[8], ((s << 1) | {7'd0, scan_in}) & mask};
        if (enable) begin
            if ($countones(d) == 1) ns = d;
            else errc = 1'b1;
        end else if (bad && rec != 0) begin
            ns   = 8'(1 << ridx);
            errc = 1'b1;
        end else if (advance) begin
            ns   = ((s << 1) | (s >> (n - 1))) & mask;
            errc = bad;
        end else begin
            errc = bad;
        end
        ne = errc ? 1'b1 : (err_clr ? 1'b0 : cur[8]);
        return {ne, ns};
    endfunction

    // Advance the models on the same edge as the DUTs.
    always @(posedge clk) begin
        ma    <= model_next(4, 0, 1, ma);
        mb    <= model_next(4, 0, 0, mb);
        mc    <= model_next(8, 7, 1, mc);
        armed <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input string p, input int n, input logic [8:0] m,
                           input logic [7:0] st, input logic [2:0] idx,
                           input logic so, input logic ill, input logic err);
        logic [7:0] s;
        logic       bad;
        s   = m[7:0];
        bad = ($countones(s) != 1);
        chk({p, ".state_out"}, {24'd0, st}, {24'd0, s});
        chk({p, ".state_idx"}, {29'd0, idx}, bad ? 32'd0 : 32'($clog2(s)));
        chk({p, ".scan_out"}, {31'd0, so}, {31'd0, s[n-1]});
        chk({p, ".illegal"}, {31'd0, ill}, {31'd0, bad});
        chk({p, ".err_sticky"}, {31'd0, err}, {31'd0, m[8]});
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            cmp_dut("A", 4, ma, {4'd0, a_state}, {1'b0, a_idx}, a_so, a_ill, a_err);
            cmp_dut("B", 4, mb, {4'd0, b_state}, {1'b0, b_idx}, b_so, b_ill, b_err);
            cmp_dut("C", 8, mc, c_state, c_idx, c_so, c_ill, c_err);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic a, input logic [7:0] d,
                       input logic s, input logic si, input logic c);
        rst = r; enable = e; advance = a; sin = d; scan_enable = s; scan_in = si; err_clr = c;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        cyc(1, 0, 0, 8'h00, 0, 0, 0);
        chk("rst A state", {28'd0, a_state}, 32'h1);
        chk("rst A idx", {30'd0, a_idx}, 32'd0);
        chk("rst A err", {31'd0, a_err}, 32'd0);
        chk("rst C state", {24'd0, c_state}, 32'h80);
        chk("rst C idx", {29'd0, c_idx}, 32'd7);
        chk("rst C scan_out", {31'd0, c_so}, 32'd1);
        // Advance with wrap
        cyc(0, 0, 1, 8'h00, 0, 0, 0);
        cyc(0, 0, 1, 8'h00, 0, 0, 0);
        cyc(0, 0, 1, 8'h00, 0, 0, 0);
        chk("adv3 A", {28'd0, a_state}, 32'h8);
        cyc(0, 0, 1, 8'h00, 0, 0, 0);
        chk("adv wrap A", {28'd0, a_state}, 32'h1);
        // Legal load, rejected load, clear
        cyc(0, 1, 0, 8'h04, 0, 0, 0);
        chk("load A", {28'd0, a_state}, 32'h4);
        chk("load A idx", {30'd0, a_idx}, 32'd2);
        cyc(0, 1, 0, 8'h06, 0, 0, 0);
        chk("bad load A hold", {28'd0, a_state}, 32'h4);
        chk("bad load A err", {31'd0, a_err}, 32'd1);
        cyc(0, 0, 0, 8'h00, 0, 0, 1);
        chk("clr A err", {31'd0, a_err}, 32'd0);
        // Scan 1,0,1,0 from 1000
        cyc(0, 0, 1, 8'h00, 0, 0, 0);
        chk("scan_out0", {31'd0, a_so}, 32'd1);
        cyc(0, 0, 0, 8'h00, 1, 1, 0);
        chk("scan_out1", {31'd0, a_so}, 32'd0);
        cyc(0, 0, 0, 8'h00, 1, 0, 0);
        chk("scan_out2", {31'd0, a_so}, 32'd0);
        cyc(0, 0, 0, 8'h00, 1, 1, 0);
        chk("scan_out3", {31'd0, a_so}, 32'd0);
        cyc(0, 0, 0, 8'h00, 1, 0, 0);
        chk("scan A state", {28'd0, a_state}, 32'hA);
        chk("scan A illegal", {31'd0, a_ill}, 32'd1);
        cyc(0, 0, 0, 8'h00, 0, 0, 0);
        chk("recover A", {28'd0, a_state}, 32'h1);
        chk("recover A err", {31'd0, a_err}, 32'd1);
        chk("norecover B", {28'd0, b_state}, 32'hA);
        chk("norecover B err", {31'd0, b_err}, 32'd1);
        // Scan in zeros; flag-only instance keeps 0000
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0);
        chk("zero B state", {28'd0, b_state}, 32'h0);
        chk("zero B illegal", {31'd0, b_ill}, 32'd1);
        chk("zero B idx", {30'd0, b_idx}, 32'd0);
        cyc(0, 1, 0, 8'h02, 0, 0, 0);
        chk("reload B", {28'd0, b_state}, 32'h2);
        chk("reload B illegal", {31'd0, b_ill}, 32'd0);
        // Simultaneous events
        cyc(1, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 8'h08, 0, 0, 0);
        chk("load beats adv", {28'd0, a_state}, 32'h8);
        cyc(0, 1, 0, 8'h04, 1, 0, 0);
        chk("scan beats load", {28'd0, a_state}, 32'h0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 0, 8'h06, 0, 0, 1);
        chk("set beats clr", {31'd0, a_err}, 32'd1);
        // Reset in the middle of a scan
        cyc(0, 0, 0, 8'h00, 1, 1, 0);
        cyc(1, 0, 0, 8'h00, 1, 1, 0);
        chk("midscan rst A", {28'd0, a_state}, 32'h1);
        chk("midscan rst err", {31'd0, a_err}, 32'd0);
        cyc(0, 0, 1, 8'h00, 0, 0, 0);
        chk("resume A", {28'd0, a_state}, 32'h2);
        chk("resume C", {24'd0, c_state}, 32'h01);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = 8'd1 << $urandom_range(0, 7);
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, d, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_hot_state_register_param.md
Name: one_hot_state_register_param

Overview:
- Parametrised N-state one-hot state register for sequencer/control paths.
- Supports parallel load, single-step advance (rotate), and a serial scan chain for DFT.
- Checks the encoding on every cycle: rejects illegal loads, recovers from corrupted states, and keeps a sticky error flag for the fault/status logic.

Parameters:
- N, 4, number of states / register width; legal range N >= 2.
- RESET_IDX, 0, index of the bit set on reset and on recovery; 0 <= RESET_IDX < N.
- RECOVER, 1, 1 = an illegal state outside scan is forced to the reset state; 0 = an illegal state is flagged only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  parallel load request.
- advance  input  1  rotate to the next state.
- state_in  input  N  parallel load value.
- scan_enable  input  1  scan shift mode.
- scan_in  input  1  serial scan data in.
- err_clr  input  1  clears err_sticky.
- state_out  output  N  registered state.
- state_idx  output  clog2(N), minimum 1  encoded index of the set bit; 0 if state_out is not one-hot.
- scan_out  output  1  equals state_out[N-1].
- illegal  output  1  combinational: state_out is not exactly one-hot.
- err_sticky  output  1  registered sticky encoding-error flag.

Behaviour:
- State register updates only on the rising edge of clk, with one cycle of latency from control inputs to state_out.
- Define onehot(x) as: exactly one bit of x is set.
- Next-state priority, highest first:
  1. rst: state <= 1<<RESET_IDX; err_sticky <= 0.
  2. scan_enable: state <= {state[N-2:0], scan_in}. Encoding is not checked and err_sticky is not updated while scanning.
  3. enable and onehot(state_in): state <= state_in.
  4. enable and !onehot(state_in): state holds; err_sticky <= 1 (load rejected).
  5. RECOVER==1 and illegal: state <= 1<<RESET_IDX; err_sticky <= 1. Recovery overrides advance.
  6. advance: state <= rotate-left by 1, with state[N-1] wrapping to bit 0. With RECOVER==0 an illegal state is also rotated and err_sticky <= 1.
  7. Otherwise hold. If illegal, err_sticky <= 1; with RECOVER==0, an illegal value persists until load, scan or reset.
- err_sticky:
  - Set only by the error conditions above.
  - When err_clr is high and no error condition exists that cycle, err_sticky <= 0.
  - If err_clr and an error condition occur in the same cycle, set wins.
  - rst overrides everything.
- enable and advance together: the load wins and advance is ignored.
- scan_enable together with enable/advance: scan wins; the others are ignored that cycle.
- Leaving scan with an illegal pattern: on the first non-scan cycle the pattern is detected under rule 5, 4 or 7 (rule 4 only if the load is itself illegal), so err_sticky sets.
- Reset mid-scan or mid-operation: state takes the reset value on the next edge and all in-flight scan data is discarded.
- state_idx is combinational from state_out, giving the lowest set bit index when one-hot and 0 otherwise.
- scan_out is combinational from state_out[N-1], so a full N-cycle shift unloads the previous contents MSB first.
- Reset values:
  - state_out = 1<<RESET_IDX
  - state_idx = RESET_IDX
  - scan_out = (RESET_IDX==N-1)
  - illegal = 0
  - err_sticky = 0

Test Plan:
1. N=4, RESET_IDX=0: assert rst for 1 cycle -> state_out=0001, state_idx=0, err_sticky=0. Pulse advance 4 cycles -> 0010, 0100, 1000, 0001 (wrap).
2. enable with state_in=0100 -> state_out=0100, state_idx=2. Then enable with state_in=0110 -> state holds at 0100, err_sticky=1. err_clr one cycle -> err_sticky=0.
3. From state 1000: scan_enable for 4 cycles, scan_in=1,0,1,0 -> scan_out sequence 1,0,0,0 and final state_out=1010. Drop scan_enable (RECOVER=1) -> illegal=1 for that cycle, next state_out=0001, err_sticky=1.
4. RECOVER=0: scan in 0000 and drop scan_enable -> state holds at 0000, illegal=1, err_sticky=1, state_idx=0. enable with state_in=0010 -> state_out=0010, illegal=0.
5. Simultaneous events: enable=1 (state_in=1000) with advance=1 from 0001 -> 1000. scan_enable=1 with enable=1 -> shift only. err_clr in the same cycle as a rejected load -> err_sticky stays 1.
6. rst asserted on scan cycle 2 of 4 -> next state_out=0001 and err_sticky=0; subsequent advance resumes normally. Repeat the scenarios with N=8, RESET_IDX=7 (reset value 1000_0000, scan_out=1).
